// File: rtl/qbus_pwrseq_pkg.sv
// Shared state encoding and tick constants for the Q-bus power sequencer.
// Ticks are 400 ns periods of the 2.5 MHz timebase.
package qbus_pwrseq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PFAIL = 2'd1,
        DCLO  = 2'd2,
        POKW  = 2'd3
    } pwr_state_e;

    localparam int unsigned TICKS_4MS  = 10000;
    localparam int unsigned TICKS_70MS = 175000;

endpackage

// File: rtl/qbus_pwrseq_sync_edge.sv
// Two-flop synchroniser with rising-edge detect for asynchronous inputs.
// A level already high when reset releases is not reported as an edge.
module sync_edge (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic rq_s_o,
    output logic rq_rise_o
);

    logic       s1_q;
    logic       s2_q;
    logic       prev_q;
    logic [1:0] vld_q;

    // Synchroniser chain; vld_q marks when s2_q carries a real sample.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            vld_q <= 2'b00;
        end else begin
            s1_q  <= d_i;
            s2_q  <= s1_q;
            vld_q <= {vld_q[0], 1'b1};
        end
    end

    // Previous level starts high and only tracks once samples are real.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q <= 1'b1;
        end else if (vld_q[1]) begin
            prev_q <= s2_q;
        end
    end

    assign rq_s_o    = s2_q;
    assign rq_rise_o = s2_q & ~prev_q;

endmodule

// File: rtl/qbus_pwrseq.sv
// Q-bus power-fail sequencer: turns a reset request into BPOK/BDCOK timing.
// Enables are registered; 1 pulls the corresponding open-drain line low.
module qbus_pwrseq
    import qbus_pwrseq_pkg::*;
#(
    parameter int unsigned T_PF  = TICKS_4MS,
    parameter int unsigned T_DC  = TICKS_4MS,
    parameter int unsigned T_POK = TICKS_70MS,
    parameter int unsigned CNT_W = 18
) (
    input  logic clock,
    input  logic nrst,
    input  logic req,
    input  logic pf_ena,
    output logic bpok_oe,
    output logic bdcok_oe,
    output logic busy,
    output logic done
);

    localparam logic [CNT_W-1:0] LD_PF  = CNT_W'(T_PF - 1);
    localparam logic [CNT_W-1:0] LD_DC  = CNT_W'(T_DC - 1);
    localparam logic [CNT_W-1:0] LD_POK = CNT_W'(T_POK - 1);

    pwr_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pf_q, pf_d;
    logic             bpok_q, bpok_d;
    logic             bdcok_q, bdcok_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             rq_s;
    logic             rq_rise;

    sync_edge u_sync (
        .clk_i     (clock),
        .rst_ni    (nrst),
        .d_i       (req),
        .rq_s_o    (rq_s),
        .rq_rise_o (rq_rise)
    );

    // Next state, phase counter and registered output values.
    always_comb begin
        state_d = state_q;
        pf_d    = pf_q;
        cnt_d   = (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;

        unique case (state_q)
            IDLE: begin
                if (rq_rise) begin
                    pf_d = pf_ena;
                    if (pf_ena) begin
                        state_d = PFAIL;
                        cnt_d   = LD_PF;
                    end else begin
                        state_d = DCLO;
                        cnt_d   = LD_DC;
                    end
                end
            end
            PFAIL: begin
                if (cnt_q == '0) begin
                    state_d = DCLO;
                    cnt_d   = LD_DC;
                end
            end
            DCLO: begin
                if (cnt_q == '0 && !rq_s) begin
                    if (pf_q) begin
                        state_d = POKW;
                        cnt_d   = LD_POK;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            POKW: begin
                if (rq_rise) begin
                    state_d = PFAIL;
                    cnt_d   = LD_PF;
                    pf_d    = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d = IDLE;
                end
            end
        endcase

        bpok_d  = 1'b0;
        bdcok_d = 1'b0;
        unique case (state_d)
            IDLE:  ;
            PFAIL: bpok_d = 1'b1;
            DCLO: begin
                bdcok_d = 1'b1;
                bpok_d  = pf_d;
            end
            POKW:  bpok_d = 1'b1;
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == IDLE) && (state_q != IDLE);
    end

    // State, counter, mode and output registers.
    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pf_q    <= 1'b0;
            bpok_q  <= 1'b0;
            bdcok_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pf_q    <= pf_d;
            bpok_q  <= bpok_d;
            bdcok_q <= bdcok_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bpok_oe  = bpok_q;
    assign bdcok_oe = bdcok_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_qbus_pwrseq.sv
// Directed bench for qbus_pwrseq with short phase parameters.
// Per-cycle traces are recorded, then edges and widths are checked.
module tb_qbus_pwrseq;

    logic clock = 1'b0;
    logic nrst;
    logic req;
    logic pf_ena;
    logic bpok_oe;
    logic bdcok_oe;
    logic busy;
    logic done;

    int checks = 0;
    int passes = 0;

    logic [0:127] bp_t;
    logic [0:127] dc_t;
    logic [0:127] by_t;
    logic [0:127] dn_t;

    qbus_pwrseq #(
        .T_PF  (4),
        .T_DC  (10),
        .T_POK (20),
        .CNT_W (18)
    ) dut (
        .clock    (clock),
        .nrst     (nrst),
        .req      (req),
        .pf_ena   (pf_ena),
        .bpok_oe  (bpok_oe),
        .bdcok_oe (bdcok_oe),
        .busy     (busy),
        .done     (done)
    );

    always #5 clock = ~clock;

    function automatic int first_at(input logic [0:127] t, input int from,
                                    input logic v);
        for (int i = from; i < 128; i++) begin
            if (t[i] === v) return i;
        end
        return -1;
    endfunction

    function automatic int cnt_hi(input logic [0:127] t);
        int c;
        c = 0;
        for (int i = 0; i < 128; i++) begin
            if (t[i] === 1'b1) c++;
        end
        return c;
    endfunction

    // Cycle n: sample #1 after posedge n, then drive req for that cycle.
    task automatic run(input int ncyc, input logic [0:127] rp,
                       input logic pf, input int flip);
        bp_t = '0;
        dc_t = '0;
        by_t = '0;
        dn_t = '0;
        @(posedge clock);
        #1;
        for (int n = 0; n < ncyc; n++) begin
            bp_t[n] = bpok_oe;
            dc_t[n] = bdcok_oe;
            by_t[n] = busy;
            dn_t[n] = done;
            req     = rp[n];
            pf_ena  = (n >= flip) ? ~pf : pf;
            @(posedge clock);
            #1;
        end
    endtask

    task automatic settle();
        int k;
        req = 1'b0;
        k   = 0;
        while (busy !== 1'b0 && k < 100) begin
            @(posedge clock);
            #1;
            k++;
        end
        checks++;
        if (busy !== 1'b0) $display("FAIL settle: busy=%b after %0d cycles, want 0", busy, k);
        else passes++;
        repeat (4) @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        nrst   = 1'b0;
        req    = 1'b0;
        pf_ena = 1'b0;
        #2;
        checks++; if (bpok_oe !== 1'b0) $display("FAIL rst_bpok: got %b want 0", bpok_oe); else passes++;
        checks++; if (bdcok_oe !== 1'b0) $display("FAIL rst_bdcok: got %b want 0", bdcok_oe); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else passes++;
        checks++; if (done !== 1'b0) $display("FAIL rst_done: got %b want 0", done); else passes++;
        #10;
        nrst = 1'b1;
        settle();
    endtask

    task automatic test_full_seq();
        logic [0:127] p;
        p = '0;
        p[0] = 1'b1;
        p[1] = 1'b1;
        run(50, p, 1'b1, 5);
        checks++; if (first_at(bp_t, 0, 1) != 3) $display("FAIL full_bpok_rise: got %0d want 3", first_at(bp_t, 0, 1)); else passes++;
        checks++; if (first_at(dc_t, 0, 1) != 7) $display("FAIL full_bdcok_rise: got %0d want 7", first_at(dc_t, 0, 1)); else passes++;
        checks++; if (first_at(dc_t, 7, 0) != 17) $display("FAIL full_bdcok_fall: got %0d want 17", first_at(dc_t, 7, 0)); else passes++;
        checks++; if (cnt_hi(dc_t) != 10) $display("FAIL full_bdcok_width: got %0d want 10", cnt_hi(dc_t)); else passes++;
        checks++; if (first_at(bp_t, 3, 0) != 37) $display("FAIL full_bpok_fall: got %0d want 37", first_at(bp_t, 3, 0)); else passes++;
        checks++; if (cnt_hi(bp_t) != 34) $display("FAIL full_bpok_width: got %0d want 34", cnt_hi(bp_t)); else passes++;
        checks++; if (cnt_hi(by_t) != 34) $display("FAIL full_busy_width: got %0d want 34", cnt_hi(by_t)); else passes++;
        checks++; if (first_at(dn_t, 0, 1) != 37) $display("FAIL full_done_pos: got %0d want 37", first_at(dn_t, 0, 1)); else passes++;
        checks++; if (cnt_hi(dn_t) != 1) $display("FAIL full_done_cnt: got %0d want 1", cnt_hi(dn_t)); else passes++;
        settle();
    endtask

    task automatic test_dc_only();
        logic [0:127] p;
        p = '0;
        p[0] = 1'b1;
        run(30, p, 1'b0, 5);
        checks++; if (cnt_hi(bp_t) != 0) $display("FAIL dco_bpok: got %0d high cycles want 0", cnt_hi(bp_t)); else passes++;
        checks++; if (first_at(dc_t, 0, 1) != 3) $display("FAIL dco_bdcok_rise: got %0d want 3", first_at(dc_t, 0, 1)); else passes++;
        checks++; if (cnt_hi(dc_t) != 10) $display("FAIL dco_bdcok_width: got %0d want 10", cnt_hi(dc_t)); else passes++;
        checks++; if (first_at(dn_t, 0, 1) != 13) $display("FAIL dco_done_pos: got %0d want 13", first_at(dn_t, 0, 1)); else passes++;
        settle();
    endtask

    task automatic test_long_req();
        logic [0:127] p;
        p = '0;
        for (int i = 0; i < 30; i++) p[i] = 1'b1;
        run(45, p, 1'b0, 999);
        checks++; if (first_at(dc_t, 0, 1) != 3) $display("FAIL long_bdcok_rise: got %0d want 3", first_at(dc_t, 0, 1)); else passes++;
        checks++; if (first_at(dc_t, 3, 0) != 33) $display("FAIL long_bdcok_fall: got %0d want 33", first_at(dc_t, 3, 0)); else passes++;
        checks++; if (cnt_hi(bp_t) != 0) $display("FAIL long_bpok: got %0d high cycles want 0", cnt_hi(bp_t)); else passes++;
        checks++; if (first_at(dn_t, 0, 1) != 33) $display("FAIL long_done_pos: got %0d want 33", first_at(dn_t, 0, 1)); else passes++;
        settle();
    endtask

    task automatic test_pokw_abort();
        logic [0:127] p;
        p = '0;
        p[0]  = 1'b1;
        p[1]  = 1'b1;
        p[21] = 1'b1;
        p[22] = 1'b1;
        run(70, p, 1'b1, 999);
        checks++; if (first_at(bp_t, 0, 1) != 3) $display("FAIL abort_bpok_rise: got %0d want 3", first_at(bp_t, 0, 1)); else passes++;
        checks++; if (first_at(bp_t, 3, 0) != 58) $display("FAIL abort_bpok_fall: got %0d want 58", first_at(bp_t, 3, 0)); else passes++;
        checks++; if (cnt_hi(bp_t) != 55) $display("FAIL abort_bpok_width: got %0d want 55", cnt_hi(bp_t)); else passes++;
        checks++; if (first_at(dc_t, 17, 1) != 28) $display("FAIL abort_dc2_rise: got %0d want 28", first_at(dc_t, 17, 1)); else passes++;
        checks++; if (first_at(dc_t, 28, 0) != 38) $display("FAIL abort_dc2_fall: got %0d want 38", first_at(dc_t, 28, 0)); else passes++;
        checks++; if (cnt_hi(dc_t) != 20) $display("FAIL abort_bdcok_width: got %0d want 20", cnt_hi(dc_t)); else passes++;
        checks++; if (first_at(dn_t, 0, 1) != 58) $display("FAIL abort_done_pos: got %0d want 58", first_at(dn_t, 0, 1)); else passes++;
        checks++; if (cnt_hi(dn_t) != 1) $display("FAIL abort_done_cnt: got %0d want 1", cnt_hi(dn_t)); else passes++;
        settle();
    endtask

    task automatic test_ignored_edges();
        logic [0:127] p;
        p = '0;
        p[0] = 1'b1;
        p[1] = 1'b1;
        p[3] = 1'b1;
        p[8] = 1'b1;
        p[9] = 1'b1;
        run(50, p, 1'b1, 999);
        checks++; if (first_at(bp_t, 3, 0) != 37) $display("FAIL ign_bpok_fall: got %0d want 37", first_at(bp_t, 3, 0)); else passes++;
        checks++; if (first_at(dc_t, 0, 1) != 7) $display("FAIL ign_bdcok_rise: got %0d want 7", first_at(dc_t, 0, 1)); else passes++;
        checks++; if (cnt_hi(dc_t) != 10) $display("FAIL ign_bdcok_width: got %0d want 10", cnt_hi(dc_t)); else passes++;
        checks++; if (cnt_hi(by_t) != 34) $display("FAIL ign_busy_width: got %0d want 34", cnt_hi(by_t)); else passes++;
        settle();
    endtask

    task automatic test_async_reset();
        logic [0:127] p;
        p = '0;
        p[0] = 1'b1;
        p[1] = 1'b1;
        for (int i = 9; i < 128; i++) p[i] = 1'b1;
        run(10, p, 1'b1, 999);
        checks++; if (bdcok_oe !== 1'b1) $display("FAIL arst_pre_bdcok: got %b want 1", bdcok_oe); else passes++;
        #3;
        nrst = 1'b0;
        #1;
        checks++; if (bdcok_oe !== 1'b0) $display("FAIL arst_bdcok: got %b want 0", bdcok_oe); else passes++;
        checks++; if (bpok_oe !== 1'b0) $display("FAIL arst_bpok: got %b want 0", bpok_oe); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL arst_busy: got %b want 0", busy); else passes++;
        #2;
        nrst = 1'b1;
        p = '1;
        run(20, p, 1'b1, 999);
        checks++; if (cnt_hi(by_t) != 0) $display("FAIL arst_held_busy: got %0d busy cycles want 0", cnt_hi(by_t)); else passes++;
        checks++; if (cnt_hi(dc_t) != 0) $display("FAIL arst_held_bdcok: got %0d high cycles want 0", cnt_hi(dc_t)); else passes++;
        p = '0;
        for (int i = 3; i < 12; i++) p[i] = 1'b1;
        run(12, p, 1'b1, 999);
        checks++; if (first_at(bp_t, 0, 1) != 6) $display("FAIL arst_retrig: got %0d want 6", first_at(bp_t, 0, 1)); else passes++;
        settle();
    endtask

    initial begin
        test_reset();
        test_full_seq();
        test_dc_only();
        test_long_req();
        test_pokw_abort();
        test_ignored_edges();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
